sysid_reader: RTL
=================

Name: sysid_reader

Overview:
- Avalon-MM read master that interrogates a system-ID slave.
- Issues a read to the ID word (address 0), then the timestamp word (address 1).
- Compares the returned ID against an expected value and reports pass or fail.
- Sits beside the processor in nios_system, so hardware can qualify the loaded system image before releasing downstream logic.

Parameters:
- EXPECTED_ID, 32'h504144E5, ID word the slave must return.
- EXPECTED_TS, 32'h00000000, expected timestamp word; used only with the optional feature.
- TIMEOUT_CYCLES, 255, maximum cycles a read may be held by waitrequest before abort; range 1..65535.
- MAX_RETRIES, 3, full-sequence retries after a mismatch before fail; range 0..15.
- AUTO_START, 1, 1 = start a check automatically on the first cycle after reset deasserts.

Ports:
- clock  input  1  single system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a check when idle or done.
- avm_address  output  1  slave word select (0 = ID, 1 = timestamp).
- avm_read  output  1  read request.
- avm_readdata  input  32  slave read data.
- avm_waitrequest  input  1  slave stall.
- busy  output  1  high while a check sequence is running.
- done  output  1  high from sequence end until the next start; sticky.
- pass  output  1  valid while done; 1 = ID (and TS if enabled) matched.
- timeout  output  1  valid while done; 1 = aborted on waitrequest timeout.
- id_value  output  32  last captured ID word.
- ts_value  output  32  last captured timestamp word.

Behaviour:
- Reset values:
  - All outputs 0, including avm_address, avm_read, id_value and ts_value.
  - State IDLE; retry counter and timeout counter cleared.
- Reset asserted mid-sequence:
  - Immediate return to IDLE on the next edge.
  - avm_read drops that same edge; any partial result is discarded.
- States: IDLE, RD_ID, RD_TS, CHECK, DONE.
- IDLE:
  - Go to RD_ID on a start pulse, or on the first post-reset cycle if AUTO_START=1.
  - Entering RD_ID clears done, pass and timeout, and sets busy.
- RD_ID:
  - avm_read=1, avm_address=0.
  - Avalon rule: read, address held stable until a cycle with avm_waitrequest=0.
  - In that cycle avm_readdata is captured into id_value (zero-wait read, no readdatavalid) and the state goes to RD_TS.
  - avm_read deasserts or changes address on the following edge; no idle cycle is required between the two reads.
- RD_TS: identical to RD_ID with avm_address=1; captures ts_value, then goes to CHECK.
- Timeout:
  - A 16-bit counter increments each cycle that avm_read=1 and avm_waitrequest=1; it clears when a transfer completes.
  - When the count reaches TIMEOUT_CYCLES: drop avm_read, set timeout=1 and pass=0, go to DONE.
  - Timeout does not consume retries.
- CHECK (one cycle, no bus activity):
  - Match: pass=1, go to DONE.
  - Mismatch with retry count < MAX_RETRIES: increment retries, go to RD_ID.
  - Mismatch otherwise: pass=0, go to DONE.
- DONE:
  - done=1, busy=0; results held.
  - A start pulse re-enters RD_ID and clears the retry counter.
- start while busy: ignored, no queuing.
- start in the same cycle as reset: reset wins. start is not an auto-start trigger; only the reset-release cycle is.
- MAX_RETRIES=0: a single attempt only.
- Latency, zero-wait slave with matching ID: start at cycle N gives done=1 at N+4.

Optional Feature:
- Macro: SYSID_READER_TS_CHECK_EN.
- Defined: CHECK additionally requires ts_value == EXPECTED_TS for a match; timestamp mismatch follows the same retry path.
- Undefined:
  - Timestamp is read and captured in ts_value only; it never affects pass.
  - EXPECTED_TS is unused.

Test Plan:
- Reset release, AUTO_START=1, zero-wait slave returning 0x504144E5 / 0x4C000000 -> reads at addr 0 then 1; done=1, pass=1, id_value=0x504144E5 four cycles after reset release.
- start, slave holds waitrequest 5 cycles on each read -> avm_read and address stable throughout each stall; done at start+14; pass=1.
- Slave returns ID 0x00000000, MAX_RETRIES=3 -> exactly 4 ID/TS read pairs; done=1, pass=0, timeout=0.
- waitrequest stuck high, TIMEOUT_CYCLES=8 -> avm_read drops after 8 stalled cycles; done=1, timeout=1, pass=0.
- reset asserted while in RD_TS with waitrequest high -> next edge avm_read=0, busy=0, done=0, id_value=0.
- With SYSID_READER_TS_CHECK_EN, EXPECTED_TS=0x4C000000, slave TS=0x4C000001, MAX_RETRIES=0 -> pass=0. Same stimulus without the macro -> pass=1.

Source files
------------

// File: rtl/sysid_reader_if.sv
// sysid_reader_if: Avalon-MM read-only bus between the sysid_reader master and
// a system-ID slave.
//   avm_address     master->slave  word select (0 = ID, 1 = timestamp)
//   avm_read        master->slave  read request
//   avm_readdata    slave->master  32-bit read data, valid when waitrequest is low
//   avm_waitrequest slave->master  stall; the request is held while this is high
`timescale 1ns/1ps
interface sysid_reader_if;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/sysid_reader.sv
// sysid_reader: Avalon-MM read master that reads the system-ID word (address 0)
// and the timestamp word (address 1), compares the ID against EXPECTED_ID and
// reports pass/fail, with retries after a mismatch and a waitrequest timeout.
// Optional feature macro: SYSID_READER_TS_CHECK_EN -- when defined, the timestamp
// must also equal EXPECTED_TS for a match.
// Ports:
//   clock, reset  rising-edge clock, synchronous active-high reset
//   start         one-cycle pulse, starts a check from IDLE or DONE
//   avm           Avalon-MM master side (address, read, readdata, waitrequest)
//   busy          check sequence in progress
//   done          sticky end-of-sequence flag, cleared by the next start
//   pass          match result, valid while done
//   timeout       sequence aborted on waitrequest timeout, valid while done
//   id_value      last captured ID word
//   ts_value      last captured timestamp word
`timescale 1ns/1ps
module sysid_reader #(
  parameter logic [31:0] EXPECTED_ID    = 32'h504144E5,
  parameter logic [31:0] EXPECTED_TS    = 32'h00000000,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  sysid_reader_if.master        avm,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic [31:0]           id_value,
  output logic [31:0]           ts_value
);

  localparam int unsigned TMO_W   = 16;
  localparam int unsigned RETRY_W = 4;
  localparam logic [TMO_W-1:0]   TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_ID = 3'd1;
  localparam logic [2:0] S_RD_TS = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]         state, state_nx;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nx;
  logic [RETRY_W-1:0] retry_cnt, retry_nx;
  logic               first_cycle;
  logic               rd_nx, addr_nx;
  logic               busy_nx, done_nx, pass_nx, timeout_nx;
  logic [31:0]        id_nx, ts_nx;
  logic               launch_c;
  logic               match_c;

  // Match condition evaluated in CHECK, after both words are captured
`ifdef SYSID_READER_TS_CHECK_EN
  assign match_c = (id_value == EXPECTED_ID) && (ts_value == EXPECTED_TS);
`else
  logic unused_expected_ts;
  assign unused_expected_ts = ^EXPECTED_TS;
  assign match_c = (id_value == EXPECTED_ID);
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nx   = state;
    tmo_nx     = tmo_cnt;
    retry_nx   = retry_cnt;
    rd_nx      = avm.avm_read;
    addr_nx    = avm.avm_address;
    busy_nx    = busy;
    done_nx    = done;
    pass_nx    = pass;
    timeout_nx = timeout;
    id_nx      = id_value;
    ts_nx      = ts_value;
    launch_c   = 1'b0;

    case (state)
      S_IDLE: begin
        // Only the first cycle after reset release counts as an auto-start
        if (start || (AUTO_START && first_cycle)) begin
          launch_c = 1'b1;
        end
      end
      S_RD_ID, S_RD_TS: begin
        if (!avm.avm_waitrequest) begin
          tmo_nx = '0;
          if (state == S_RD_ID) begin
            id_nx    = avm.avm_readdata;
            addr_nx  = 1'b1;
            state_nx = S_RD_TS;
          end else begin
            ts_nx    = avm.avm_readdata;
            rd_nx    = 1'b0;
            addr_nx  = 1'b0;
            state_nx = S_CHECK;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          // Abort without consuming a retry
          tmo_nx     = '0;
          rd_nx      = 1'b0;
          addr_nx    = 1'b0;
          timeout_nx = 1'b1;
          pass_nx    = 1'b0;
          done_nx    = 1'b1;
          busy_nx    = 1'b0;
          state_nx   = S_DONE;
        end else begin
          tmo_nx = tmo_cnt + TMO_W'(1);
        end
      end
      S_CHECK: begin
        if (match_c) begin
          pass_nx  = 1'b1;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = S_DONE;
        end else if (retry_cnt < RETRY_MAX) begin
          retry_nx = retry_cnt + RETRY_W'(1);
          rd_nx    = 1'b1;
          addr_nx  = 1'b0;
          state_nx = S_RD_ID;
        end else begin
          pass_nx  = 1'b0;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          launch_c = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        rd_nx    = 1'b0;
        addr_nx  = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase

    // Fresh sequence: clear status and retry budget, issue the ID read
    if (launch_c) begin
      state_nx   = S_RD_ID;
      retry_nx   = '0;
      tmo_nx     = '0;
      rd_nx      = 1'b1;
      addr_nx    = 1'b0;
      busy_nx    = 1'b1;
      done_nx    = 1'b0;
      pass_nx    = 1'b0;
      timeout_nx = 1'b0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= S_IDLE;
      tmo_cnt         <= '0;
      retry_cnt       <= '0;
      first_cycle     <= 1'b1;
      avm.avm_read    <= 1'b0;
      avm.avm_address <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      timeout         <= 1'b0;
      id_value        <= '0;
      ts_value        <= '0;
    end else begin
      state           <= state_nx;
      tmo_cnt         <= tmo_nx;
      retry_cnt       <= retry_nx;
      first_cycle     <= 1'b0;
      avm.avm_read    <= rd_nx;
      avm.avm_address <= addr_nx;
      busy            <= busy_nx;
      done            <= done_nx;
      pass            <= pass_nx;
      timeout         <= timeout_nx;
      id_value        <= id_nx;
      ts_value        <= ts_nx;
    end
  end

endmodule
